// File: rtl/hdr_wr_buffer.sv
// ============================================================================
// Module   : hdr_wr_buffer
// Purpose  : Buffers tone-mapper writes and hands them to the SDRAM
//            controller one request at a time, in arrival order.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module hdr_wr_buffer #(
    parameter int          DEPTH     = 4,
    parameter logic [24:0] LAST_ADDR = 25'h12C000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_req,
    input  logic [127:0]  wr_data,
    input  logic [24:0]   wr_address,
    output logic          ram_busy,
    output logic          sd_wr_req,
    output logic [127:0]  sd_wr_data,
    output logic [24:0]   sd_wr_address,
    input  logic          sd_wr_ack,
    output logic          frame_written,
    output logic          overflow
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_BUSY = c_CNT_W'(DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_ONE  = c_CNT_W'(1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t               r_state;
    logic [152:0]         r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;

    logic                 w_push;
    logic                 w_pop;
    logic [c_PTR_W-1:0]   w_rd_next;

    assign w_push    = wr_req && (r_count != c_FULL);
    assign w_pop     = (r_state == REQ) && sd_wr_ack;
    assign w_rd_next = r_rd_ptr + 1'b1;
    assign ram_busy  = (r_count >= c_BUSY);

    // Storage carries no reset: only slots covered by r_count are ever read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {wr_address, wr_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_next;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (wr_req && !w_push) begin
                overflow <= 1'b1;
            end
        end
    end

    // The head entry stays counted until acknowledged; on ack the next entry
    // (or a same-cycle push into a one-deep queue) is presented straight away.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            sd_wr_req     <= 1'b0;
            sd_wr_data    <= '0;
            sd_wr_address <= '0;
            frame_written <= 1'b0;
        end else begin
            frame_written <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (r_count != '0) begin
                        sd_wr_req                    <= 1'b1;
                        {sd_wr_address, sd_wr_data}  <= r_mem[r_rd_ptr];
                        r_state                      <= REQ;
                    end
                end
                REQ: begin
                    if (sd_wr_ack) begin
                        frame_written <= (sd_wr_address == LAST_ADDR);
                        if (r_count > c_ONE) begin
                            {sd_wr_address, sd_wr_data} <= r_mem[w_rd_next];
                        end else if (w_push) begin
                            {sd_wr_address, sd_wr_data} <= {wr_address, wr_data};
                        end else begin
                            sd_wr_req <= 1'b0;
                            r_state   <= IDLE;
                        end
                    end
                end
                default: begin
                    sd_wr_req <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hdr_wr_buffer.sv
// ============================================================================
// Module   : tb_hdr_wr_buffer
// Purpose  : Directed bench for hdr_wr_buffer with a queue-based model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hdr_wr_buffer;

    localparam int          DEPTH = 4;
    localparam logic [24:0] LAST  = 25'h12C000;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_req;
    logic [127:0]  wr_data;
    logic [24:0]   wr_address;
    logic          ram_busy;
    logic          sd_wr_req;
    logic [127:0]  sd_wr_data;
    logic [24:0]   sd_wr_address;
    logic          sd_wr_ack;
    logic          frame_written;
    logic          overflow;

    int n_checks = 0;
    int n_errors = 0;
    int fw_cnt   = 0;

    logic [152:0]  m_q [$];
    logic          m_req = 1'b0;
    logic [152:0]  m_out = '0;
    logic          m_fw  = 1'b0;
    logic          m_ovf = 1'b0;

    logic [24:0]   got [$];
    logic [24:0]   exp_q [$];

    hdr_wr_buffer #(.DEPTH(DEPTH), .LAST_ADDR(LAST)) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_req        (wr_req),
        .wr_data       (wr_data),
        .wr_address    (wr_address),
        .ram_busy      (ram_busy),
        .sd_wr_req     (sd_wr_req),
        .sd_wr_data    (sd_wr_data),
        .sd_wr_address (sd_wr_address),
        .sd_wr_ack     (sd_wr_ack),
        .frame_written (frame_written),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [24:0] a, input logic [127:0] d);
        wr_req     = 1'b1;
        wr_address = a;
        wr_data    = d;
        tick();
        wr_req     = 1'b0;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic expect_got(input string nm);
        chk({nm, "_count"}, 128'(got.size()), 128'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            chk($sformatf("%s_addr%0d", nm, i), 128'(got[i]), 128'(exp_q[i]));
        end
    endtask

    // Reference model: a queue of pending entries plus the request on offer.
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_q.delete();
            m_req = 1'b0;
            m_out = '0;
            m_fw  = 1'b0;
            m_ovf = 1'b0;
        end else begin
            int   pre;
            logic ack_t;
            pre   = m_q.size();
            ack_t = m_req && sd_wr_ack;
            m_fw  = ack_t && (m_out[152:128] == LAST);
            if (ack_t) void'(m_q.pop_front());
            if (wr_req) begin
                if (pre < DEPTH) m_q.push_back({wr_address, wr_data});
                else             m_ovf = 1'b1;
            end
            if (m_req) begin
                if (ack_t) begin
                    if (m_q.size() > 0) m_out = m_q[0];
                    else                m_req = 1'b0;
                end
            end else if (pre > 0) begin
                m_req = 1'b1;
                m_out = m_q[0];
            end
        end
    end

    initial forever begin
        @(negedge clk);
        chk("ram_busy", ram_busy, (m_q.size() >= DEPTH - 1));
        chk("sd_wr_req", sd_wr_req, m_req);
        chk("frame_written", frame_written, m_fw);
        chk("overflow", overflow, m_ovf);
        if (m_req || rst) begin
            chk("sd_wr_address", sd_wr_address, m_out[152:128]);
            chk("sd_wr_data", sd_wr_data, m_out[127:0]);
        end
        if (sd_wr_req && sd_wr_ack && !rst) got.push_back(sd_wr_address);
        if (frame_written) fw_cnt++;
    end

    initial begin
        rst        = 1'b1;
        wr_req     = 1'b0;
        wr_data    = '0;
        wr_address = '0;
        sd_wr_ack  = 1'b0;
        repeat (3) tick();
        chk("reset_sd_wr_req", sd_wr_req, 1'b0);
        chk("reset_overflow", overflow, 1'b0);
        rst = 1'b0;
        repeat (5) tick();

        // Single write, ack held high: request two edges after the strobe.
        sd_wr_ack = 1'b1;
        push(25'hE1000, {16{8'hA5}});
        chk("single_not_yet", sd_wr_req, 1'b0);
        tick();
        chk("single_req", sd_wr_req, 1'b1);
        chk("single_addr", sd_wr_address, 25'hE1000);
        chk("single_data", sd_wr_data, {16{8'hA5}});
        tick();
        chk("single_done", sd_wr_req, 1'b0);
        repeat (2) tick();

        // Fill with ack low, then overflow, then drain.
        sd_wr_ack = 1'b0;
        got.delete();
        push(25'hE2000, rnd128());
        push(25'hE2004, rnd128());
        chk("fill_busy2", ram_busy, 1'b0);
        push(25'hE2008, rnd128());
        chk("fill_busy3", ram_busy, 1'b1);
        push(25'hE200C, rnd128());
        chk("fill_no_ovf", overflow, 1'b0);
        push(25'hE2010, rnd128());
        chk("fill_ovf", overflow, 1'b1);
        repeat (2) tick();
        sd_wr_ack = 1'b1;
        repeat (8) tick();
        exp_q = '{25'hE2000, 25'hE2004, 25'hE2008, 25'hE200C};
        expect_got("fill_drain");

        // Back-to-back drain of three entries.
        got.delete();
        push(25'hE1000, rnd128());
        push(25'hE1004, rnd128());
        push(25'hE1008, rnd128());
        repeat (4) tick();
        exp_q = '{25'hE1000, 25'hE1004, 25'hE1008};
        expect_got("b2b");
        chk("b2b_idle", sd_wr_req, 1'b0);

        // Simultaneous push and pop at count 2.
        sd_wr_ack = 1'b0;
        got.delete();
        push(25'h3000, rnd128());
        push(25'h3004, rnd128());
        tick();
        sd_wr_ack = 1'b1;
        push(25'h3008, rnd128());
        sd_wr_ack = 1'b0;
        chk("pp_busy2", ram_busy, 1'b0);
        push(25'h300C, rnd128());
        chk("pp_busy3", ram_busy, 1'b1);
        sd_wr_ack = 1'b1;
        repeat (6) tick();
        exp_q = '{25'h3000, 25'h3004, 25'h3008, 25'h300C};
        expect_got("pushpop");

        // Frame end detection.
        fw_cnt = 0;
        push(25'h12BFFC, rnd128());
        repeat (4) tick();
        chk("frame_near_last", 128'(fw_cnt), 128'(0));
        push(25'h12C000, rnd128());
        repeat (4) tick();
        chk("frame_last", 128'(fw_cnt), 128'(1));

        // Asynchronous reset while a request is outstanding.
        sd_wr_ack = 1'b0;
        got.delete();
        push(25'h4000, rnd128());
        push(25'h4004, rnd128());
        tick();
        chk("rst_pre_req", sd_wr_req, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_req", sd_wr_req, 1'b0);
        chk("rst_async_addr", sd_wr_address, 25'h0);
        chk("rst_async_busy", ram_busy, 1'b0);
        chk("rst_async_ovf", overflow, 1'b0);
        tick();
        rst = 1'b0;
        sd_wr_ack = 1'b1;
        repeat (5) tick();
        chk("rst_no_req", sd_wr_req, 1'b0);
        chk("rst_no_delivery", 128'(got.size()), 128'(0));
        push(25'h4010, rnd128());
        tick();
        chk("rst_new_req", sd_wr_req, 1'b1);
        chk("rst_new_addr", sd_wr_address, 25'h4010);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hdr_wr_buffer.md
HDR_WR_BUFFER -- requirements
Module: hdr_wr_buffer

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entries; power of two, minimum 2.
REQ-002 Parameter LAST_ADDR, default 25'h12C000, RAM word address of the final write of a tone-mapped frame.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 wr_req  input  1  one-cycle write strobe from tone mapper.
REQ-006 wr_data  input  128  eight RGB565 pixels, valid when wr_req=1.
REQ-007 wr_address  input  25  RAM word address, valid when wr_req=1.
REQ-008 ram_busy  output  1  back-pressure to tone mapper.
REQ-009 sd_wr_req  output  1  write request to SDRAM controller.
REQ-010 sd_wr_data  output  128  data for the current request.
REQ-011 sd_wr_address  output  25  address for the current request.
REQ-012 sd_wr_ack  input  1  controller accepted the current request this cycle.
REQ-013 frame_written  output  1  one-cycle pulse when the LAST_ADDR write is acknowledged.
REQ-014 overflow  output  1  sticky: a write was dropped.

Function
REQ-015 FIFO stores {wr_address, wr_data} pairs; count ranges 0..DEPTH; read/write pointers wrap modulo DEPTH.
REQ-016 Push when wr_req=1 and count<DEPTH; on push, count increments at the same clock edge.
REQ-017 wr_req=1 with count=DEPTH: entry dropped, FIFO unchanged, overflow set to 1 at the next edge; overflow clears only on reset.
REQ-018 ram_busy = (count >= DEPTH-1), decoded from the registered count; one free slot is therefore guaranteed for a strobe issued the cycle after ram_busy rises.
REQ-019 FSM states: IDLE, REQ.
REQ-020 IDLE, count>0: register sd_wr_req=1, sd_wr_address/sd_wr_data = FIFO head; go to REQ.
REQ-021 REQ: hold sd_wr_req and outputs stable until sd_wr_ack=1.
REQ-022 On sd_wr_ack=1 in REQ: pop head. If count>1 before the pop (or a push occurs in the same cycle), stay in REQ and load the next entry in the following cycle, so back-to-back requests are possible. Otherwise deassert sd_wr_req and return to IDLE.
REQ-023 sd_wr_ack while in IDLE is ignored.
REQ-024 Simultaneous push and pop: count unchanged and both operations complete.
REQ-025 Latency: wr_req in cycle N with FIFO empty and FSM in IDLE -> sd_wr_req=1 first in cycle N+2, carrying that entry.
REQ-026 frame_written=1 for exactly the cycle after an ack whose sd_wr_address==LAST_ADDR; 0 otherwise.
REQ-027 Write ordering to the controller equals arrival order; no entry is duplicated or reordered.

Reset
REQ-028 While rst=1 (asserted asynchronously, released synchronously to clk): count=0, pointers=0, FSM=IDLE, sd_wr_req=0, sd_wr_data=0, sd_wr_address=0, ram_busy=0, frame_written=0, overflow=0.
REQ-029 Reset mid-request: sd_wr_req drops immediately and buffered entries are discarded; no pending ack is honoured after release.

Verification
REQ-030 Single write: wr_req at cycle 10, addr 25'hE1000, data 128'hA5...; ack held high -> sd_wr_req=1 at cycle 12 with the same address and data, then returns low, count=0.
REQ-031 Fill with ack=0: four strobes on DEPTH=4 -> ram_busy=1 after the third push; fifth strobe -> overflow=1 and the first four entries are delivered in order after ack resumes.
REQ-032 Back-to-back drain: three entries, ack held high -> three requests with addresses E1000, E1004, E1008 in order; sd_wr_req drops after the third.
REQ-033 Push/pop in the same cycle at count=2 -> count stays 2 and data integrity holds.
REQ-034 Frame end: entry at 25'h12C000 acknowledged -> frame_written pulses for one cycle; entry at 25'h12BFFC -> no pulse.
REQ-035 Assert rst while in REQ with two entries buffered -> outputs reach their reset values without waiting for a clock edge; after release, no request is issued until a new wr_req arrives.
